// File: rtl/prefetch_queue.sv
// Instruction-byte prefetch FIFO: fetches the reset vector, then streams PC-tagged bytes.
// Optional same-cycle memory-to-head bypass when PREFETCH_BYPASS_EN is defined (assumes ADDR_WIDTH == 2*REG_WIDTH).
module prefetch_queue #(
  parameter int                    REG_WIDTH  = 8,
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] VEC_ADDR   = 16'hFFFC
) (
  input  logic                         phi1,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [ADDR_WIDTH-1:0]        flush_addr,
  output logic                         mem_rd,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic                         mem_ack,
  input  logic [REG_WIDTH-1:0]         mem_data,
  input  logic                         pop,
  output logic                         head_valid,
  output logic [REG_WIDTH-1:0]         head_data,
  output logic [ADDR_WIDTH-1:0]        head_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         running
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0]         ONE_P   = PW'(1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {VLO, VHI, RUN} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] fetch_pc, fetch_pc_next;
  logic [REG_WIDTH-1:0]  data_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_q   [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count_next;
  logic                  mem_rd_next;
  logic                  acked, bypass_hit, do_push, do_pop;

  // An ack only counts against an outstanding request; a late ack after reset is ignored.
  assign acked = mem_rd && mem_ack;

`ifdef PREFETCH_BYPASS_EN
  assign bypass_hit = (state == RUN) && acked && !flush && (count == '0);
  assign head_valid = (count != '0) || bypass_hit;
  assign head_data  = bypass_hit ? mem_data : data_q[rd_ptr];
  assign head_pc    = bypass_hit ? fetch_pc : pc_q[rd_ptr];
`else
  assign bypass_hit = 1'b0;
  assign head_valid = (count != '0);
  assign head_data  = data_q[rd_ptr];
  assign head_pc    = pc_q[rd_ptr];
`endif

  assign do_pop  = pop && (count != '0) && !flush;
  assign do_push = (state == RUN) && acked && !flush && (count != DEPTH_C) && !(bypass_hit && pop);

  always_ff @(posedge phi1 or posedge reset) begin
    if (reset) begin
      state    <= VLO;
      fetch_pc <= '0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
    end
  end

  // Flush overrides any same-cycle ack, including during the vector fetch.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    if (flush) begin
      state_next    = RUN;
      fetch_pc_next = flush_addr;
    end else if (acked) begin
      case (state)
        VLO: begin
          fetch_pc_next[REG_WIDTH-1:0] = mem_data;
          state_next                   = VHI;
        end
        VHI: begin
          fetch_pc_next[ADDR_WIDTH-1:REG_WIDTH] = mem_data;
          state_next                            = RUN;
        end
        RUN: begin
          if (count != DEPTH_C) fetch_pc_next = fetch_pc + ONE_A;
        end
        default: state_next = VLO;
      endcase
    end
  end

  always_comb begin
    mem_addr = fetch_pc;
    running  = 1'b0;
    case (state)
      VLO:     mem_addr = VEC_ADDR;
      VHI:     mem_addr = VEC_ADDR + ONE_A;
      RUN:     running  = 1'b1;
      default: mem_addr = fetch_pc;
    endcase
  end

  always_comb begin
    count_next = count;
    if (flush) count_next = '0;
    else if (do_push && !do_pop) count_next = count + CW'(1);
    else if (do_pop && !do_push) count_next = count - CW'(1);
  end

  // A raised request is held until acked; otherwise request whenever there is room.
  always_comb begin
    if (mem_rd && !mem_ack) mem_rd_next = 1'b1;
    else if (state_next != RUN) mem_rd_next = 1'b1;
    else mem_rd_next = (count_next != DEPTH_C);
  end

  always_ff @(posedge phi1 or posedge reset) begin
    if (reset) begin
      mem_rd <= 1'b0;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      mem_rd <= mem_rd_next;
      count  <= count_next;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) begin
          data_q[wr_ptr] <= mem_data;
          pc_q[wr_ptr]   <= fetch_pc;
          wr_ptr         <= wr_ptr + ONE_P;
        end
        if (do_pop) rd_ptr <= rd_ptr + ONE_P;
      end
    end
  end

endmodule
